// File: rtl/txepreambl.sv
// Transmit preamble inserter: prefixes each packet with seven 8'h55 bytes and
// the start-of-frame byte 8'h5d while an 8-deep delay line holds the packet.
// When insertion is disabled, input bytes are registered straight through.
module txepreambl (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_busy
);

  // state    | meaning
  // IDLE     | no packet in flight; pass-through when r_en=0
  // PREAMBLE | emitting 8'h55 x7 then 8'h5d while the delay line fills
  // DATA     | emitting the delayed packet bytes from the delay-line tail
  // WAIT     | dropping a burst that started before the previous packet drained
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, WAIT} state_t;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'h5d;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       r_en, r_en_nxt;
  logic       closed, closed_nxt;
  logic       o_v_nxt;
  logic [7:0] o_d_nxt;

  logic [7:0]       dl_v;
  logic [7:0][7:0]  dl_d;
  logic             tail_v;
  logic [7:0]       tail_d;

  assign tail_v = dl_v[7];
  assign tail_d = dl_d[7];
  assign o_busy = (state != IDLE);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    r_en_nxt   = r_en;
    closed_nxt = closed;
    o_v_nxt    = o_v;
    o_d_nxt    = o_d;
    case (state)
      IDLE: begin
        // Mode only changes in a true idle gap so a packet is never split.
        if (!i_v && !o_v) r_en_nxt = i_en;
        if (!r_en) begin
          o_v_nxt = i_v;
          o_d_nxt = i_v ? i_d : 8'h00;
        end else if (i_v) begin
          state_nxt = PREAMBLE;
          cnt_nxt   = 3'd1;
          o_v_nxt   = 1'b1;
          o_d_nxt   = PRE_BYTE;
        end else begin
          o_v_nxt = 1'b0;
          o_d_nxt = 8'h00;
        end
      end
      PREAMBLE: begin
        // Valid for all 8 bytes even if the packet input already ended.
        o_v_nxt = 1'b1;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          o_d_nxt   = SFD_BYTE;
          state_nxt = DATA;
        end else begin
          o_d_nxt = PRE_BYTE;
        end
      end
      DATA: begin
        o_v_nxt = tail_v;
        o_d_nxt = tail_v ? tail_d : 8'h00;
        if (!tail_v) state_nxt = i_v ? WAIT : IDLE;
      end
      WAIT: begin
        o_v_nxt = 1'b0;
        o_d_nxt = 8'h00;
        if (!i_v) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Once the packet input drops, anything further is a new burst and is blocked.
    if (state_nxt == IDLE)
      closed_nxt = 1'b0;
    else if (state != IDLE && !i_v)
      closed_nxt = 1'b1;
  end

  // State, control and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      r_en   <= 1'b0;
      closed <= 1'b0;
      o_v    <= 1'b0;
      o_d    <= 8'h00;
      dl_v   <= 8'h00;
    end else if (i_ce) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      r_en   <= r_en_nxt;
      closed <= closed_nxt;
      o_v    <= o_v_nxt;
      o_d    <= o_d_nxt;
      dl_v   <= {dl_v[6:0], i_v && !closed};
    end
  end

  // Delay-line data; only the valid bits need reset.
  always_ff @(posedge i_clk) begin
    if (i_ce) dl_d <= {dl_d[6:0], i_d};
  end

endmodule

// File: tb/tb_txepreambl.sv
// Scoreboard bench for txepreambl: stimulus pushes expected (byte, ce-edge)
// pairs, a monitor pops and compares on every output byte.
module tb_txepreambl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_ce = 1'b0;
  logic       i_en = 1'b0;
  logic       i_v = 1'b0;
  logic [7:0] i_d = 8'h00;
  logic       o_v;
  logic [7:0] o_d;
  logic       o_busy;

  txepreambl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en),
    .i_v(i_v), .i_d(i_d), .o_v(o_v), .o_d(o_d), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] d;
    int         edge_no;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         ce_idx = 0;
  int         busy_lo = 0;
  int         busy_hi = 0;
  int         ready_edge = 0;
  int         last_k = 0;
  int         ce_gap = 1;
  logic [7:0] pkt[16];
  int         len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at ce edge %0d", name, act, exp, ce_idx);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int edge_no);
    exp_t x;
    x.d = d;
    x.edge_no = edge_no;
    sb.push_back(x);
  endtask

  // One i_ce edge with the given inputs, then ce_gap-1 clocks with i_ce low.
  task automatic tick(input logic v, input logic [7:0] d, input logic rst);
    int e;
    i_v = v; i_d = d; i_reset = rst; i_ce = 1'b1;
    e = ce_idx + 1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("busy", 32'(o_busy), 32'(e >= busy_lo && e < busy_hi));
    if (rst) begin
      check("rst_v", 32'(o_v), 32'd0);
      check("rst_d", 32'(o_d), 32'd0);
    end
    i_ce = 1'b0; i_reset = 1'b0;
    for (int g = 1; g < ce_gap; g++) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
  endtask

  task automatic idle_until_ready();
    do tick(1'b0, 8'($urandom), 1'b0); while (ce_idx + 1 < ready_edge);
  endtask

  // Reference model: enabled packet starting at edge k gives preamble j at k+j
  // and byte n at k+8+n; pass-through gives byte n at the edge it is presented.
  task automatic send_packet(input logic en);
    int k;
    i_en = en;
    idle_until_ready();
    k = ce_idx + 1;
    last_k = k;
    if (en) begin
      for (int j = 0; j < 8; j++) push_exp((j == 7) ? 8'h5d : 8'h55, k + j);
      busy_lo = k; busy_hi = k + 8 + len; ready_edge = k + 10 + len;
    end else begin
      busy_lo = 0; busy_hi = 0; ready_edge = k + len + 2;
    end
    for (int n = 0; n < len; n++) begin
      push_exp(pkt[n], en ? k + 8 + n : k + n);
      if ($urandom_range(0, 3) == 0) i_en = ~i_en;
      tick(1'b1, pkt[n], 1'b0);
    end
  endtask

  // Monitor: compare every output byte against the scoreboard, check holds.
  initial begin
    logic e_ce, e_rst, prev_v;
    logic [7:0] prev_d;
    exp_t x;
    prev_v = 1'b0; prev_d = 8'h00;
    forever begin
      @(posedge i_clk);
      e_ce = i_ce; e_rst = i_reset;
      if (i_ce) ce_idx++;
      #1;
      if (!e_rst) begin
        if (!e_ce) begin
          check("hold_v", 32'(o_v), 32'(prev_v));
          check("hold_d", 32'(o_d), 32'(prev_d));
        end else if (o_v) begin
          if (sb.size() == 0) begin
            check("unexpected_byte", 32'(o_d), 32'hffffffff);
          end else begin
            x = sb.pop_front();
            check("data", 32'(o_d), 32'(x.d));
            check("edge", ce_idx, x.edge_no);
          end
        end else begin
          check("idle_d", 32'(o_d), 32'd0);
          if (sb.size() > 0) begin
            check("missing_byte", 32'(sb[0].edge_no > ce_idx), 32'd1);
            if (sb[0].edge_no <= ce_idx) void'(sb.pop_front());
          end
        end
      end
      prev_v = o_v; prev_d = o_d;
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m;
    @(negedge i_clk);
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    ready_edge = ce_idx + 2;

    // Directed enabled packet, i_ce every clock.
    len = 3; pkt[0] = 8'hA1; pkt[1] = 8'hB2; pkt[2] = 8'hC3;
    send_packet(1'b1);

    // Same packet, i_ce every 4th clock.
    ce_gap = 4;
    send_packet(1'b1);
    ce_gap = 1;

    // Pass-through with preamble-looking bytes.
    len = 3; pkt[0] = 8'h55; pkt[1] = 8'h5d; pkt[2] = 8'h01;
    send_packet(1'b0);

    // One-byte packet.
    len = 1; pkt[0] = 8'h7E;
    send_packet(1'b1);

    // Second burst while the first packet is still draining is dropped.
    len = 3;
    for (int n = 0; n < 3; n++) pkt[n] = 8'($urandom);
    send_packet(1'b1);
    k = last_k;
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    m = $urandom_range(1, 12);
    busy_hi = (k + 11 > k + 5 + m) ? k + 11 : k + 5 + m;
    ready_edge = busy_hi + 2;
    for (int n = 0; n < m; n++) tick(1'b1, 8'($urandom), 1'b0);

    // Reset at the fourth preamble byte, then a full packet.
    i_en = 1'b1;
    idle_until_ready();
    k = ce_idx + 1;
    for (int j = 0; j < 4; j++) push_exp(8'h55, k + j);
    busy_lo = k; busy_hi = k + 4;
    for (int j = 0; j < 4; j++) tick(1'b1, 8'($urandom), 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    ready_edge = k + 6;
    len = 2; pkt[0] = 8'h3C; pkt[1] = 8'hC3;
    send_packet(1'b1);

    // Randomized packets, modes and i_ce spacing.
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 12);
      ce_gap = $urandom_range(1, 3);
      for (int n = 0; n < len; n++) pkt[n] = 8'($urandom);
      send_packet(1'($urandom_range(0, 1)));
    end

    ce_gap = 1;
    idle_until_ready();
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
